// File: rtl/secuenciador_producto.sv
// secuenciador_producto: command/result sequencer in front of the 8088 multiply/divide product unit.
// Optional macro DIV_ZERO_TRAP_EN: zero-divisor divides trap without starting the divider.
module secuenciador_producto #(
  parameter int unsigned TIMEOUT_CYC = 40,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [15:0] cmd_d,
  output logic        pu_ena,
  output logic [3:0]  pu_op,
  output logic [15:0] pu_a,
  output logic [15:0] pu_b,
  output logic [15:0] pu_d,
  input  logic [15:0] pu_r1,
  input  logic [15:0] pu_r2,
  input  logic        pu_of,
  input  logic        pu_cf,
  input  logic        pu_fin,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_r1,
  output logic [15:0] res_r2,
  output logic        res_of,
  output logic        res_cf,
  output logic        res_err,
  output logic        res_tmo
);

  typedef enum logic [2:0] {IDLE, EXEC, WAIT_FIN, HOLD, TRAP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               cmd_ready_nxt, pu_ena_nxt, res_valid_nxt;
  logic [3:0]         pu_op_nxt;
  logic [15:0]        pu_a_nxt, pu_b_nxt, pu_d_nxt;
  logic [15:0]        res_r1_nxt, res_r2_nxt;
  logic               res_of_nxt, res_cf_nxt, res_err_nxt, res_tmo_nxt;
  logic               cmd_div;
  logic               tmo_hit;

  assign cmd_div = (cmd_op[3:2] == 2'b01);
  // Last permitted WAIT_FIN cycle: the counter has counted TIMEOUT_CYC-1 earlier cycles.
  assign tmo_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef DIV_ZERO_TRAP_EN
  logic div_zero;
  assign div_zero = cmd_op[0] ? (cmd_b == 16'h0000) : (cmd_b[7:0] == 8'h00);
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      pu_ena    <= 1'b0;
      res_valid <= 1'b0;
      pu_op     <= '0;
      pu_a      <= '0;
      pu_b      <= '0;
      pu_d      <= '0;
      res_r1    <= '0;
      res_r2    <= '0;
      res_of    <= 1'b0;
      res_cf    <= 1'b0;
      res_err   <= 1'b0;
      res_tmo   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd_ready <= cmd_ready_nxt;
      pu_ena    <= pu_ena_nxt;
      res_valid <= res_valid_nxt;
      pu_op     <= pu_op_nxt;
      pu_a      <= pu_a_nxt;
      pu_b      <= pu_b_nxt;
      pu_d      <= pu_d_nxt;
      res_r1    <= res_r1_nxt;
      res_r2    <= res_r2_nxt;
      res_of    <= res_of_nxt;
      res_cf    <= res_cf_nxt;
      res_err   <= res_err_nxt;
      res_tmo   <= res_tmo_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless a state changes it.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cmd_ready_nxt = cmd_ready;
    pu_ena_nxt    = pu_ena;
    res_valid_nxt = res_valid;
    pu_op_nxt     = pu_op;
    pu_a_nxt      = pu_a;
    pu_b_nxt      = pu_b;
    pu_d_nxt      = pu_d;
    res_r1_nxt    = res_r1;
    res_r2_nxt    = res_r2;
    res_of_nxt    = res_of;
    res_cf_nxt    = res_cf;
    res_err_nxt   = res_err;
    res_tmo_nxt   = res_tmo;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (cmd_valid) begin
          pu_op_nxt     = cmd_op;
          pu_a_nxt      = cmd_a;
          pu_b_nxt      = cmd_b;
          pu_d_nxt      = cmd_d;
          cmd_ready_nxt = 1'b0;
          if (cmd_div) begin
`ifdef DIV_ZERO_TRAP_EN
            if (div_zero) begin
              state_nxt = TRAP;
            end else begin
              state_nxt  = WAIT_FIN;
              pu_ena_nxt = 1'b1;
            end
`else
            state_nxt  = WAIT_FIN;
            pu_ena_nxt = 1'b1;
`endif
          end else begin
            state_nxt = EXEC;
          end
        end
      end

      EXEC: begin
        res_r1_nxt    = pu_r1;
        res_r2_nxt    = pu_r2;
        res_of_nxt    = pu_of;
        res_cf_nxt    = pu_cf;
        res_err_nxt   = 1'b0;
        res_tmo_nxt   = 1'b0;
        res_valid_nxt = 1'b1;
        state_nxt     = HOLD;
      end

      WAIT_FIN: begin
        cnt_nxt = cnt + CNT_W'(1);
        // pu_fin takes priority over a timeout landing in the same cycle.
        if (pu_fin) begin
          res_r1_nxt    = pu_r1;
          res_r2_nxt    = pu_r2;
          res_of_nxt    = pu_of;
          res_cf_nxt    = pu_cf;
          res_err_nxt   = 1'b0;
          res_tmo_nxt   = 1'b0;
          pu_ena_nxt    = 1'b0;
          res_valid_nxt = 1'b1;
          state_nxt     = HOLD;
        end else if (tmo_hit) begin
          res_r1_nxt    = '0;
          res_r2_nxt    = '0;
          res_of_nxt    = 1'b0;
          res_cf_nxt    = 1'b0;
          res_err_nxt   = 1'b1;
          res_tmo_nxt   = 1'b1;
          pu_ena_nxt    = 1'b0;
          res_valid_nxt = 1'b1;
          state_nxt     = HOLD;
        end
      end

      TRAP: begin
        res_r1_nxt    = '0;
        res_r2_nxt    = '0;
        res_of_nxt    = 1'b0;
        res_cf_nxt    = 1'b0;
        res_err_nxt   = 1'b1;
        res_tmo_nxt   = 1'b0;
        res_valid_nxt = 1'b1;
        state_nxt     = HOLD;
      end

      HOLD: begin
        if (res_ready) begin
          res_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt     = IDLE;
        cnt_nxt       = '0;
        cmd_ready_nxt = 1'b1;
        pu_ena_nxt    = 1'b0;
        res_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
